spi_update_rx: RTL and testbench

SPI_UPDATE_RX -- requirements
Module: spi_update_rx

---
 rtl/spi_update_rx_if.sv | 24 ++
 rtl/spi_update_rx.sv | 147 ++++++++++++++
 tb/tb_spi_update_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_update_rx_if.sv
// SPI pins and decoded DDS-update outputs of spi_update_rx, bundled for port connection.
interface spi_update_rx_if;
    logic        i_sclk;
    logic        i_mosi;
    logic        i_cs_n;
    logic        o_SPI_flag;
    logic [31:0] o_SPI_tuning_code;
    logic [7:0]  o_SPI_voice_index;
    logic        o_frame_err;
    logic [7:0]  o_err_count;
    logic        o_busy;

    modport slave (
        input  i_sclk, i_mosi, i_cs_n,
        output o_SPI_flag, o_SPI_tuning_code, o_SPI_voice_index,
        output o_frame_err, o_err_count, o_busy
    );

    modport master (
        output i_sclk, i_mosi, i_cs_n,
        input  o_SPI_flag, o_SPI_tuning_code, o_SPI_voice_index,
        input  o_frame_err, o_err_count, o_busy
    );
endinterface

// File: rtl/spi_update_rx.sv
// SPI (mode 0) receiver turning 5-byte voice/tuning frames into rate-limited DDS update pulses.
// Build macro SPI_CHECKSUM_EN: frames grow to 6 bytes, the last being the XOR of the first five.
module spi_update_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_GAP     = 5
) (
    input logic            i_clk,
    input logic            i_reset_n,
    spi_update_rx_if.slave bus
);
`ifdef SPI_CHECKSUM_EN
    localparam int FRAME_BITS = 48;
`else
    localparam int FRAME_BITS = 40;
`endif
    localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, ABORT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, flush;
    logic                   sclk_s, mosi_s, cs_s, flushed;
    logic                   sclk_prev, cs_prev, armed;
    state_t                 state;
    logic [5:0]             bit_cnt;
    logic [FRAME_BITS-2:0]  shift_reg;
    logic [FRAME_BITS-1:0]  frame_next;
    logic                   pend_full;
    logic [7:0]             pend_voice;
    logic [31:0]            pend_tuning;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   flag_q, err_q;
    logic [31:0]            tuning_q;
    logic [7:0]             voice_q, err_cnt_q;
    logic                   sclk_rise, cs_fall, frame_end, frame_ok;
    logic                   drain, load, overrun, bad_sum, err_now;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign flushed = flush[SYNC_STAGES-1];

    // Synchronizers restart at the idle bus level; flush marks when their outputs reflect real pins again.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            flush     <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_cs_n};
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_prev;
    // A frame may only start after CS_n has been genuinely seen high, so a reset mid-frame never resumes it.
    assign cs_fall    = armed & cs_prev & ~cs_s;
    assign frame_next = {shift_reg, mosi_s};
    assign frame_end  = (state == SHIFT) & ~cs_s & sclk_rise & (bit_cnt == 6'(FRAME_BITS - 1));
`ifdef SPI_CHECKSUM_EN
    assign frame_ok   = (frame_next[7:0] == (frame_next[47:40] ^ frame_next[39:32] ^ frame_next[31:24]
                                             ^ frame_next[23:16] ^ frame_next[15:8]));
`else
    assign frame_ok   = 1'b1;
`endif
    assign drain      = pend_full & (gap_cnt == '0);
    assign load       = frame_end & frame_ok & (~pend_full | drain);
    assign overrun    = frame_end & frame_ok & pend_full & ~drain;
    assign bad_sum    = frame_end & ~frame_ok;
    assign err_now    = (state == ABORT) | overrun | bad_sum;

    // The completed frame is captured on its final SCLK edge so the update can issue on the next cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            sclk_prev   <= 1'b0;
            cs_prev     <= 1'b1;
            armed       <= 1'b0;
            pend_full   <= 1'b0;
            pend_voice  <= '0;
            pend_tuning <= '0;
            gap_cnt     <= '0;
            flag_q      <= 1'b0;
            tuning_q    <= '0;
            voice_q     <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            armed     <= armed | (flushed & cs_s);

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state <= ABORT;
                    end else if (sclk_rise) begin
                        shift_reg <= frame_next[FRAME_BITS-2:0];
                        bit_cnt   <= bit_cnt + 6'd1;
                        if (frame_end) state <= DONE;
                    end
                end
                DONE: begin
                    if (cs_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                pend_full   <= 1'b1;
                pend_voice  <= frame_next[FRAME_BITS-1 -: 8];
                pend_tuning <= frame_next[FRAME_BITS-9 -: 32];
            end else if (drain) begin
                pend_full <= 1'b0;
            end

            flag_q <= drain;
            if (drain) begin
                tuning_q <= pend_tuning;
                voice_q  <= pend_voice;
                gap_cnt  <= GAP_W'(MIN_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            err_q <= err_now;
            if (err_now && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.o_SPI_flag        = flag_q;
    assign bus.o_SPI_tuning_code = tuning_q;
    assign bus.o_SPI_voice_index = voice_q;
    assign bus.o_frame_err       = err_q;
    assign bus.o_err_count       = err_cnt_q;
    assign bus.o_busy            = (state != IDLE) | pend_full;
endmodule

// File: tb/tb_spi_update_rx.sv
// Randomized self-checking bench for spi_update_rx against a frame-level expectation model.
// Honors SPI_CHECKSUM_EN to pick the frame length and checksum scenarios.
module tb_spi_update_rx;
    localparam int TB_SYNC    = 2;
    localparam int TB_MIN_GAP = 700;
    localparam int HALF       = 3;
`ifdef SPI_CHECKSUM_EN
    localparam int FBITS = 48;
`else
    localparam int FBITS = 40;
`endif

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    spi_update_rx_if bus();

    spi_update_rx #(.SYNC_STAGES(TB_SYNC), .MIN_GAP(TB_MIN_GAP)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int failures = 0;
    int cycle = 0;
    int nErrs = 0;
    int lastRise = 0;
    int expErr = 0;
    logic [7:0]  gotVoice[$];
    logic [31:0] gotTune[$];
    int          gotCycle[$];
    logic [7:0]  expVoice[$];
    logic [31:0] expTune[$];

    always @(posedge i_clk) cycle <= cycle + 1;

    always @(negedge i_clk) begin
        if (bus.o_SPI_flag) begin
            gotVoice.push_back(bus.o_SPI_voice_index);
            gotTune.push_back(bus.o_SPI_tuning_code);
            gotCycle.push_back(cycle);
        end
        if (bus.o_frame_err) nErrs <= nErrs + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    function automatic logic [47:0] makeFrame(input logic [7:0] v, input logic [31:0] t);
`ifdef SPI_CHECKSUM_EN
        logic [7:0] s;
        s = v ^ t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0];
        return {v, t, s};
`else
        return {8'h00, v, t};
`endif
    endfunction

    task automatic shiftBits(input logic [47:0] frame, input int first, input int last);
        for (int i = first; i < last; i++) begin
            bus.i_mosi = frame[FBITS-1-i];
            waitCycles(HALF);
            bus.i_sclk = 1'b1;
            lastRise = cycle;
            waitCycles(HALF);
            bus.i_sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [47:0] frame, input int nbits);
        bus.i_cs_n = 1'b0;
        waitCycles(HALF);
        shiftBits(frame, 0, nbits);
        waitCycles(HALF);
        bus.i_cs_n = 1'b1;
        waitCycles(2 * HALF);
    endtask

    task automatic expectFrame(input logic [47:0] frame);
        expVoice.push_back(frame[FBITS-1 -: 8]);
        expTune.push_back(frame[FBITS-9 -: 32]);
    endtask

    task automatic checkFlags(input string tag);
        int n;
        n = expVoice.size();
        checkOutput({tag, "_nflags"}, gotVoice.size(), n);
        for (int i = 0; i < n && i < gotVoice.size(); i++) begin
            checkOutput({tag, "_voice"}, gotVoice[i], expVoice[i]);
            checkOutput({tag, "_tuning"}, gotTune[i], expTune[i]);
        end
        checkOutput({tag, "_errcnt"}, bus.o_err_count, (expErr > 255) ? 255 : expErr);
        gotVoice.delete();
        gotTune.delete();
        gotCycle.delete();
        expVoice.delete();
        expTune.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_flag"},   bus.o_SPI_flag, 0);
        checkOutput({tag, "_tuning"}, bus.o_SPI_tuning_code, 0);
        checkOutput({tag, "_voice"},  bus.o_SPI_voice_index, 0);
        checkOutput({tag, "_err"},    bus.o_frame_err, 0);
        checkOutput({tag, "_errcnt"}, bus.o_err_count, 0);
        checkOutput({tag, "_busy"},   bus.o_busy, 0);
    endtask

    initial begin
        logic [47:0] f1, f2, f3;
        int errBase, lat, kind;

        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        bus.i_cs_n = 1'b1;
        i_reset_n  = 1'b0;
        waitCycles(3);
        checkResetOutputs("reset");
        i_reset_n = 1'b1;
        waitCycles(10);

        // Single known frame, including issue latency from the last SCLK edge.
        f1 = makeFrame(8'h03, 32'h01234567);
        applyStimulus(f1, FBITS);
        waitCycles(20);
        lat = (gotCycle.size() > 0) ? gotCycle[0] - lastRise : 9999;
        checkOutput("latency_ok", lat <= TB_SYNC + 2, 1);
        checkOutput("single_idle_busy", bus.o_busy, 0);
        expectFrame(f1);
        checkFlags("single");
        waitCycles(TB_MIN_GAP + 20);

        errBase = nErrs;
        applyStimulus(makeFrame(8'h11, 32'hCAFEF00D), 17);
        waitCycles(20);
        expErr++;
        checkOutput("abort17_pulses", nErrs - errBase, 1);
        checkFlags("abort17");
        waitCycles(TB_MIN_GAP + 20);

        // Three frames inside one gap window: issue, hold pending, overrun.
        errBase = nErrs;
        f1 = makeFrame(8'hA1, 32'h11111111);
        f2 = makeFrame(8'hA2, 32'h22222222);
        f3 = makeFrame(8'hA3, 32'h33333333);
        applyStimulus(f1, FBITS);
        applyStimulus(f2, FBITS);
        applyStimulus(f3, FBITS);
        waitCycles(TB_MIN_GAP + 40);
        expectFrame(f1);
        expectFrame(f2);
        expErr++;
        checkOutput("b2b_spacing_ok", (gotCycle.size() == 2) ? (gotCycle[1] - gotCycle[0] >= TB_MIN_GAP) : 0, 1);
        checkOutput("b2b_err_pulses", nErrs - errBase, 1);
        checkFlags("b2b");
        waitCycles(TB_MIN_GAP + 20);

`ifdef SPI_CHECKSUM_EN
        errBase = nErrs;
        applyStimulus({8'h03, 32'h01234567, 8'h00}, FBITS);
        waitCycles(20);
        expErr++;
        checkOutput("badsum_pulses", nErrs - errBase, 1);
        checkFlags("badsum");
        waitCycles(TB_MIN_GAP + 20);
`endif

        // Reset in the middle of byte 2, then finish clocking the dead frame.
        f1 = makeFrame(8'h5A, 32'hDEADBEEF);
        bus.i_cs_n = 1'b0;
        waitCycles(HALF);
        shiftBits(f1, 0, 20);
        i_reset_n = 1'b0;
        waitCycles(1);
        checkResetOutputs("midreset");
        i_reset_n = 1'b1;
        expErr = 0;
        errBase = nErrs;
        shiftBits(f1, 20, FBITS);
        waitCycles(HALF);
        bus.i_cs_n = 1'b1;
        waitCycles(30);
        checkOutput("midreset_err_pulses", nErrs - errBase, 0);
        checkFlags("midreset_tail");
        f2 = makeFrame(8'h42, 32'h0BADCAFE);
        applyStimulus(f2, FBITS);
        waitCycles(20);
        expectFrame(f2);
        checkFlags("post_reset");
        waitCycles(TB_MIN_GAP + 20);

        for (int n = 0; n < 12; n++) begin
`ifdef SPI_CHECKSUM_EN
            kind = $urandom_range(0, 3);
`else
            kind = $urandom_range(0, 2);
`endif
            f1 = makeFrame(8'($urandom), $urandom);
            errBase = nErrs;
            if (kind == 0) begin
                applyStimulus(f1, $urandom_range(1, FBITS - 1));
                expErr++;
            end else if (kind == 3) begin
                f1[7:0] = f1[7:0] ^ 8'($urandom_range(1, 255));
                applyStimulus(f1, FBITS);
                expErr++;
            end else begin
                applyStimulus(f1, FBITS);
                expectFrame(f1);
            end
            waitCycles(TB_MIN_GAP + 30);
            checkOutput("rand_err_pulses", nErrs - errBase, (kind == 0 || kind == 3) ? 1 : 0);
            checkFlags("rand");
        end

        errBase = nErrs;
        for (int n = 0; n < 300; n++) applyStimulus(makeFrame(8'h00, 32'h0), 2);
        waitCycles(20);
        expErr += 300;
        checkOutput("sat_err_pulses", nErrs - errBase, 300);
        checkFlags("saturate");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
